fp_add_pipe: RTL and testbench
==============================

# fp_add_pipe

Parametrised, fully pipelined IEEE-754-style floating-point adder/subtractor. It supersedes the fixed single-precision combinational stage chain (mask → align → alu → normalize → pack) with a registered 4-stage datapath. The datapath takes generic exponent and mantissa widths, applies round-to-nearest-even, raises exception flags and carries a tag. A valid/ready handshake with full backpressure lets it sit directly between the operand source and the result consumer in the FP unit.

## Interface
Parameters:
- EXP_W, 8, exponent field width (≥4); bias = 2^(EXP_W-1)-1
- MAN_W, 23, stored mantissa (fraction) width (≥4); word width W = 1+EXP_W+MAN_W (localparam)
- TAG_W, 4, width of sideband tag carried alongside each operation

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  operand pair presented
- in_ready  out  1  block accepts operands this cycle
- a  in  W  operand A {sign, exponent, fraction}
- b  in  W  operand B
- sub  in  1  0: A+B, 1: A−B (B sign inverted at stage 1)
- in_tag  in  TAG_W  sideband, returned unchanged with result
- out_valid  out  1  result presented
- out_ready  in  1  consumer accepts result
- result  out  W  rounded sum
- out_tag  out  TAG_W  tag of this result
- flags  out  4  {invalid, overflow, underflow, inexact}

## Operation
- Stage 1 (unpack): split fields, apply sub, classify zero/sub/inf/NaN, swap so |X| ≥ |Y|, compute exponent difference d.
- Stage 2 (align): shift Y significand (hidden bit included) right by min(d, MAN_W+3); produce guard, round and sticky bits (sticky = OR of all bits shifted past round).
- Stage 3 (alu): effective add or subtract on MAN_W+4 bits; record carry-out and result sign (sign of X).
- Stage 4 (normalize/round/pack): on carry, shift right 1 and exp+1; otherwise leading-zero count, shift left and subtract from exp (clamped at the subnormal boundary). RNE: increment when G & (R|S|LSB); re-normalise on mantissa overflow. Pack and set flags.
- Special cases, evaluated in stage 4 from stage-1 class bits:
  - any NaN input → canonical qNaN (sign 0, exp all ones, fraction MSB 1, rest 0); invalid=0 unless signalling NaN
  - +inf + −inf (after sub) → canonical qNaN, invalid=1
  - inf with finite → that inf, flags 0
  - exact zero result of unlike signs → +0; (−0)+(−0) → −0
  - exponent ≥ all-ones after rounding → ±inf, overflow=1, inexact=1
- inexact = G|R|S after normalisation. underflow = tiny result AND inexact.

## Timing
- Latency: 4 cycles from accepted input (in_valid & in_ready) to out_valid, with no stalls. Throughput: 1 operation/cycle.
- Global stall: advance = !out_valid | out_ready. in_ready = advance & !reset. All stage registers load only when advance=1; stage valid bits shift with advance.
- Bubbles propagate as valid=0. A stalled pipeline holds all stages; no operation is dropped or duplicated.
- While out_valid=1 & out_ready=0, result, out_tag and flags stay stable.
- in_valid with in_ready=0: no acceptance; source must hold. in_valid=0 with advance=1 inserts a bubble.
- Reset (any cycle, including mid-stream): all stage valids clear next edge, in-flight operations discarded. Reset values: out_valid 0, result 0, out_tag 0, flags 0, in_ready 0 during reset, 1 the cycle after.
- Order of results equals order of acceptance.

## Configuration
- FP_ADD_SUBNORMAL_EN defined: subnormal inputs use hidden bit 0 and exponent 1. Tiny results are produced as subnormals; underflow follows the rule above.
- Undefined: flush-to-zero. Subnormal inputs are treated as signed zero. Any result below the minimum normal becomes signed zero with underflow=1 and inexact=1. Stage-4 left-shift clamping logic is omitted.

## Test plan
- Default params, 1.0+2.0 (0x3F800000, 0x40000000, sub=0), out_ready=1 → 0x40400000, flags 0, out_valid exactly 4 cycles after acceptance.
- 0x3F800000 − 0x3F800000 → 0x00000000; 0x7F800000 − 0x7F800000 → 0x7FC00000, invalid=1.
- 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000, overflow=1, inexact=1; 0x3F800000 + 0x33800000 (tie) → 0x3F800000, inexact=1.
- Stream 8 tagged ops back-to-back, out_ready low for cycles 5–7 → in_ready low while stalled, 8 results in tag order 0..7, none lost or repeated; assert reset mid-stream → out_valid 0 next cycle, no stale results afterwards.
- 0x00000001 + 0x00000001 → 0x00000002, flags 0 with FP_ADD_SUBNORMAL_EN; 0x00000000 without it.
- EXP_W=5, MAN_W=10 (half): 0x3C00 + 0x3C00 → 0x4000; 0x7BFF + 0x7BFF → 0x7C00, overflow=1.

Source files
------------

// File: rtl/fp_add_pipe.sv
// fp_add_pipe: 4-stage pipelined floating-point adder/subtractor with
// round-to-nearest-even, exception flags and a sideband tag.
// Optional feature macro: FP_ADD_SUBNORMAL_EN (gradual underflow);
// when undefined, subnormal inputs and tiny results flush to signed zero.
//
// Handshake: an operand pair is accepted on a rising edge where
// in_valid & in_ready; a result is consumed on a rising edge where
// out_valid & out_ready. The whole pipe advances together when the output
// register is empty or being consumed (advance = !out_valid | out_ready),
// so a stall freezes every stage and result/out_tag/flags hold steady.
module fp_add_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    input  logic                 sub,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] result,
    output logic [TAG_W-1:0]     out_tag,
    output logic [3:0]           flags
);
    localparam int W   = 1 + EXP_W + MAN_W;
    localparam int SW  = MAN_W + 4;          // hidden + fraction + G/R/S
    localparam int AW  = 2 * (MAN_W + 3);    // alignment window
    localparam int LZW = $clog2(SW + 1);
    localparam int CW  = ((EXP_W > LZW) ? EXP_W : LZW) + 2;
    localparam logic [CW-1:0] EXP_ONES = CW'((1 << EXP_W) - 1);
    localparam logic [CW-1:0] MAX_SH   = CW'(MAN_W + 3);
    localparam logic [CW-1:0] ONE      = CW'(1);

    logic w_advance;
    assign w_advance = !out_valid | out_ready;
    assign in_ready  = w_advance & !reset;

    // ---------------- stage 1: unpack, classify, swap ----------------
    logic             w_a_sign, w_b_sign, w_a_ez, w_b_ez, w_a_eo, w_b_eo;
    logic             w_a_nan, w_b_nan, w_a_snan, w_b_snan, w_a_inf, w_b_inf;
    logic             w_a_ge, w_inf_clash;
    logic [EXP_W-1:0] w_a_expf, w_b_expf, w_a_e, w_b_e, w_x_e, w_y_e;
    logic [MAN_W-1:0] w_a_frac, w_b_frac;
    logic [MAN_W:0]   w_a_sig, w_b_sig;
    logic [3:0]       w_spec;  // {nan_out, invalid, inf_out, inf_sign}

    assign {w_a_sign, w_a_expf, w_a_frac} = a;
    assign w_b_sign = b[W-1] ^ sub;
    assign w_b_expf = b[W-2:MAN_W];
    assign w_b_frac = b[MAN_W-1:0];
    assign w_a_eo   = &w_a_expf;
    assign w_b_eo   = &w_b_expf;
    assign w_a_ez   = ~|w_a_expf;
    assign w_b_ez   = ~|w_b_expf;
    assign w_a_nan  = w_a_eo & (|w_a_frac);
    assign w_b_nan  = w_b_eo & (|w_b_frac);
    assign w_a_snan = w_a_nan & !w_a_frac[MAN_W-1];
    assign w_b_snan = w_b_nan & !w_b_frac[MAN_W-1];
    assign w_a_inf  = w_a_eo & ~|w_a_frac;
    assign w_b_inf  = w_b_eo & ~|w_b_frac;
    assign w_inf_clash = w_a_inf & w_b_inf & (w_a_sign ^ w_b_sign);
    assign w_spec = {w_a_nan | w_b_nan | w_inf_clash,
                     w_a_snan | w_b_snan | w_inf_clash,
                     w_a_inf | w_b_inf,
                     w_a_inf ? w_a_sign : w_b_sign};

`ifdef FP_ADD_SUBNORMAL_EN
    // Subnormals: hidden bit 0, effective exponent 1.
    assign w_a_e   = w_a_ez ? EXP_W'(1) : w_a_expf;
    assign w_b_e   = w_b_ez ? EXP_W'(1) : w_b_expf;
    assign w_a_sig = {!w_a_ez, w_a_frac};
    assign w_b_sig = {!w_b_ez, w_b_frac};
`else
    // Flush-to-zero: a zero exponent field means a signed zero.
    assign w_a_e   = w_a_ez ? '0 : w_a_expf;
    assign w_b_e   = w_b_ez ? '0 : w_b_expf;
    assign w_a_sig = w_a_ez ? '0 : {1'b1, w_a_frac};
    assign w_b_sig = w_b_ez ? '0 : {1'b1, w_b_frac};
`endif

    assign w_a_ge = {w_a_e, w_a_sig} >= {w_b_e, w_b_sig};
    assign w_x_e  = w_a_ge ? w_a_e : w_b_e;
    assign w_y_e  = w_a_ge ? w_b_e : w_a_e;

    logic             r_s1_valid, r_s1_sign, r_s1_eff_sub;
    logic [TAG_W-1:0] r_s1_tag;
    logic [3:0]       r_s1_spec;
    logic [EXP_W-1:0] r_s1_exp, r_s1_diff;
    logic [MAN_W:0]   r_s1_sig_x, r_s1_sig_y;

    // Stage 1 register: larger-magnitude operand becomes X.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
        end else if (w_advance) begin
            r_s1_valid   <= in_valid;
            r_s1_tag     <= in_tag;
            r_s1_spec    <= w_spec;
            r_s1_sign    <= w_a_ge ? w_a_sign : w_b_sign;
            r_s1_eff_sub <= w_a_sign ^ w_b_sign;
            r_s1_exp     <= w_x_e;
            r_s1_diff    <= w_x_e - w_y_e;
            r_s1_sig_x   <= w_a_ge ? w_a_sig : w_b_sig;
            r_s1_sig_y   <= w_a_ge ? w_b_sig : w_a_sig;
        end
    end

    // ---------------- stage 2: align Y ----------------
    logic [CW-1:0] w_d, w_sh_y;
    logic [AW-1:0] w_wide;
    logic [SW-1:0] w_y_al;

    assign w_d    = CW'(r_s1_diff);
    assign w_sh_y = (w_d > MAX_SH) ? MAX_SH : w_d;
    assign w_wide = {r_s1_sig_y, {(MAN_W + 5){1'b0}}} >> w_sh_y;
    assign w_y_al = {w_wide[AW-1:MAN_W+3], |w_wide[MAN_W+2:0]};

    logic             r_s2_valid, r_s2_sign, r_s2_eff_sub;
    logic [TAG_W-1:0] r_s2_tag;
    logic [3:0]       r_s2_spec;
    logic [EXP_W-1:0] r_s2_exp;
    logic [SW-1:0]    r_s2_x, r_s2_y;

    // Stage 2 register: aligned significands with guard/round/sticky.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s2_valid <= 1'b0;
        end else if (w_advance) begin
            r_s2_valid   <= r_s1_valid;
            r_s2_tag     <= r_s1_tag;
            r_s2_spec    <= r_s1_spec;
            r_s2_sign    <= r_s1_sign;
            r_s2_eff_sub <= r_s1_eff_sub;
            r_s2_exp     <= r_s1_exp;
            r_s2_x       <= {r_s1_sig_x, 3'b000};
            r_s2_y       <= w_y_al;
        end
    end

    // ---------------- stage 3: add / subtract ----------------
    logic [SW:0] w_sum;
    assign w_sum = r_s2_eff_sub ? ({1'b0, r_s2_x} - {1'b0, r_s2_y})
                                : ({1'b0, r_s2_x} + {1'b0, r_s2_y});

    logic             r_s3_valid, r_s3_sign, r_s3_eff_sub;
    logic [TAG_W-1:0] r_s3_tag;
    logic [3:0]       r_s3_spec;
    logic [EXP_W-1:0] r_s3_exp;
    logic [SW:0]      r_s3_sum;

    // Stage 3 register: raw sum with carry-out; X >= Y so no negation needed.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s3_valid <= 1'b0;
        end else if (w_advance) begin
            r_s3_valid   <= r_s2_valid;
            r_s3_tag     <= r_s2_tag;
            r_s3_spec    <= r_s2_spec;
            r_s3_sign    <= r_s2_sign;
            r_s3_eff_sub <= r_s2_eff_sub;
            r_s3_exp     <= r_s2_exp;
            r_s3_sum     <= w_sum;
        end
    end

    // ---------------- stage 4: normalize, round, pack ----------------
    logic [CW-1:0]    w_lz, w_sh, w_exp_x, w_exp_n, w_exp_r;
    logic [SW-1:0]    w_norm;
    logic [MAN_W:0]   w_mant;
    logic [MAN_W+1:0] w_rnd;
    logic [MAN_W-1:0] w_frac;
    logic [EXP_W-1:0] w_exp_field;
    logic             w_hidden, w_tiny, w_flush, w_inexact, w_inc;
    logic [W-1:0]     w_res;
    logic [3:0]       w_flg;

    // Leading-zero count of the sum below the carry bit.
    always_comb begin
        w_lz = CW'(SW);
        for (int i = 0; i < SW; i++) begin
            if (r_s3_sum[i]) w_lz = CW'(SW - 1 - i);
        end
    end

    // Normalize: right by one on carry, else left by the leading-zero count.
    always_comb begin
        w_exp_x = CW'(r_s3_exp);
        w_sh    = '0;
        w_tiny  = 1'b0;
        w_flush = 1'b0;
        w_norm  = '0;
        w_exp_n = w_exp_x;
        if (r_s3_sum[SW]) begin
            w_norm  = {r_s3_sum[SW:2], r_s3_sum[1] | r_s3_sum[0]};
            w_exp_n = w_exp_x + ONE;
        end else begin
`ifdef FP_ADD_SUBNORMAL_EN
            // Stop shifting at exponent 1; a clear hidden bit marks a subnormal.
            w_sh    = (w_lz > w_exp_x - ONE) ? (w_exp_x - ONE) : w_lz;
            w_norm  = r_s3_sum[SW-1:0] << w_sh;
            w_exp_n = w_exp_x - w_sh;
            w_tiny  = !w_norm[SW-1];
`else
            w_sh    = w_lz;
            w_norm  = r_s3_sum[SW-1:0] << w_sh;
            w_exp_n = w_exp_x - w_sh;
            w_tiny  = (w_lz >= w_exp_x);
            w_flush = w_tiny;
`endif
        end
    end

    // Round to nearest even, re-normalize on mantissa overflow, then pack.
    always_comb begin
        w_mant    = w_norm[SW-1:3];
        w_inexact = |w_norm[2:0];
        w_inc     = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
        w_rnd     = {1'b0, w_mant} + {{(MAN_W + 1){1'b0}}, w_inc};
        if (w_rnd[MAN_W+1]) begin
            w_frac   = w_rnd[MAN_W:1];
            w_hidden = 1'b1;
            w_exp_r  = w_exp_n + ONE;
        end else begin
            w_frac   = w_rnd[MAN_W-1:0];
            w_hidden = w_rnd[MAN_W];
            w_exp_r  = w_exp_n;
        end
        w_exp_field = w_hidden ? w_exp_r[EXP_W-1:0] : {EXP_W{1'b0}};
        w_res = '0;
        w_flg = '0;
        if (r_s3_spec[3]) begin
            w_res = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W - 1){1'b0}}};
            w_flg = {r_s3_spec[2], 3'b000};
        end else if (r_s3_spec[1]) begin
            w_res = {r_s3_spec[0], {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (r_s3_sum == '0) begin
            w_res = {!r_s3_eff_sub & r_s3_sign, {(W - 1){1'b0}}};
        end else if (w_flush) begin
            w_res = {r_s3_sign, {(W - 1){1'b0}}};
            w_flg = 4'b0011;
        end else if (w_exp_r >= EXP_ONES) begin
            w_res = {r_s3_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            w_flg = 4'b0101;
        end else begin
            w_res = {r_s3_sign, w_exp_field, w_frac};
            w_flg = {2'b00, w_tiny & w_inexact, w_inexact};
        end
    end

    logic             r_out_valid;
    logic [W-1:0]     r_result;
    logic [TAG_W-1:0] r_out_tag;
    logic [3:0]       r_flags;

    // Output register: holds while the consumer stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_out_tag   <= '0;
            r_flags     <= '0;
        end else if (w_advance) begin
            r_out_valid <= r_s3_valid;
            if (r_s3_valid) begin
                r_result  <= w_res;
                r_out_tag <= r_s3_tag;
                r_flags   <= w_flg;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign out_tag   = r_out_tag;
    assign flags     = r_flags;
endmodule

// File: tb/tb_fp_add_pipe.sv
// tb_fp_add_pipe: directed tests for fp_add_pipe (single and half precision).
module tb_fp_add_pipe;
  logic        clk, reset;
  logic        in_valid, in_ready, sub, out_valid, out_ready;
  logic [31:0] a, b, result;
  logic [3:0]  in_tag, out_tag, flags;
  logic        h_in_valid, h_in_ready, h_sub, h_out_valid, h_out_ready;
  logic [15:0] h_a, h_b, h_result;
  logic [3:0]  h_in_tag, h_out_tag, h_flags;
  int          total, bad;
  logic [31:0] exp_q[$];
  logic [3:0]  tag_q[$];

  fp_add_pipe dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .out_tag(out_tag), .flags(flags)
  );

  fp_add_pipe #(.EXP_W(5), .MAN_W(10), .TAG_W(4)) dut_h (
    .clk(clk), .reset(reset), .in_valid(h_in_valid), .in_ready(h_in_ready),
    .a(h_a), .b(h_b), .sub(h_sub), .in_tag(h_in_tag), .out_valid(h_out_valid),
    .out_ready(h_out_ready), .result(h_result), .out_tag(h_out_tag), .flags(h_flags)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver: one operation on the single-precision instance
  task automatic do_op(input logic [31:0] ta, input logic [31:0] tb, input logic ts,
                       input logic [3:0] tt, output logic [31:0] r, output logic [3:0] f,
                       output logic [3:0] tg, output int lat);
    @(negedge clk);
    a = ta; b = tb; sub = ts; in_tag = tt; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    r = result; f = flags; tg = out_tag;
  endtask

  // driver: one operation on the half-precision instance
  task automatic do_op_h(input logic [15:0] ta, input logic [15:0] tb,
                         output logic [15:0] r, output logic [3:0] f, output int lat);
    @(negedge clk);
    h_a = ta; h_b = tb; h_sub = 1'b0; h_in_tag = 4'd3; h_in_valid = 1'b1;
    @(posedge clk); #1;
    h_in_valid = 1'b0;
    lat = 1;
    while (!h_out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    r = h_result; f = h_flags;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (result !== 32'h0) begin bad++; $display("FAIL reset_result got=%h want=0", result); end
    total++; if (out_tag !== 4'h0) begin bad++; $display("FAIL reset_out_tag got=%h want=0", out_tag); end
    total++; if (flags !== 4'h0) begin bad++; $display("FAIL reset_flags got=%b want=0000", flags); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_arith();
    logic [31:0] va [12] = '{32'h3F800000, 32'h3F800000, 32'h7F800000, 32'h7F7FFFFF,
                             32'h3F800000, 32'h3F800001, 32'h3FC00000, 32'h7FC00001,
                             32'h7F800001, 32'hFF800000, 32'h80000000, 32'h3F7FFFFF};
    logic [31:0] vb [12] = '{32'h40000000, 32'h3F800000, 32'h7F800000, 32'h7F7FFFFF,
                             32'h33800000, 32'h33800000, 32'h40300000, 32'h3F800000,
                             32'h3F800000, 32'h3F800000, 32'h80000000, 32'h33800000};
    logic        vs [12] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
                             1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [31:0] vr [12] = '{32'h40400000, 32'h00000000, 32'h7FC00000, 32'h7F800000,
                             32'h3F800000, 32'h3F800002, 32'hBFA00000, 32'h7FC00000,
                             32'h7FC00000, 32'hFF800000, 32'h80000000, 32'h3F800000};
    logic [3:0]  vf [12] = '{4'b0000, 4'b0000, 4'b1000, 4'b0101, 4'b0001, 4'b0001,
                             4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
    logic [31:0] r;
    logic [3:0]  f, tg;
    int          lat;
    for (int i = 0; i < 12; i++) begin
      do_op(va[i], vb[i], vs[i], i[3:0], r, f, tg, lat);
      total++; if (lat !== 4) begin bad++; $display("FAIL arith%0d_latency got=%0d want=4", i, lat); end
      total++; if (r !== vr[i]) begin bad++; $display("FAIL arith%0d_result got=%h want=%h", i, r, vr[i]); end
      total++; if (f !== vf[i]) begin bad++; $display("FAIL arith%0d_flags got=%b want=%b", i, f, vf[i]); end
      total++; if (tg !== i[3:0]) begin bad++; $display("FAIL arith%0d_tag got=%h want=%h", i, tg, i[3:0]); end
    end
  endtask

  task automatic test_subnormal();
    logic [31:0] r, want;
    logic [3:0]  f, tg;
    int          lat;
`ifdef FP_ADD_SUBNORMAL_EN
    want = 32'h00000002;
`else
    want = 32'h00000000;
`endif
    do_op(32'h00000001, 32'h00000001, 1'b0, 4'd9, r, f, tg, lat);
    total++; if (r !== want) begin bad++; $display("FAIL subnormal_result got=%h want=%h", r, want); end
    total++; if (f !== 4'b0000) begin bad++; $display("FAIL subnormal_flags got=%b want=0000", f); end
  endtask

  task automatic test_half();
    logic [15:0] r;
    logic [3:0]  f;
    int          lat;
    do_op_h(16'h3C00, 16'h3C00, r, f, lat);
    total++; if (lat !== 4) begin bad++; $display("FAIL half_one_latency got=%0d want=4", lat); end
    total++; if (r !== 16'h4000) begin bad++; $display("FAIL half_one_result got=%h want=4000", r); end
    total++; if (f !== 4'b0000) begin bad++; $display("FAIL half_one_flags got=%b want=0000", f); end
    do_op_h(16'h7BFF, 16'h7BFF, r, f, lat);
    total++; if (r !== 16'h7C00) begin bad++; $display("FAIL half_ovf_result got=%h want=7c00", r); end
    total++; if (f !== 4'b0101) begin bad++; $display("FAIL half_ovf_flags got=%b want=0101", f); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [8] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                              32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
    logic [31:0] dbl  [8] = '{32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000,
                              32'h41200000, 32'h41400000, 32'h41600000, 32'h41800000};
    logic [31:0] held_res, want;
    logic [3:0]  held_tag, want_tag;
    int          sent, got, stale;
    sent = 0; got = 0; held_res = '0; held_tag = '0;
    exp_q.delete(); tag_q.delete();
    for (int c = 0; c < 60 && got < 8; c++) begin
      @(negedge clk);
      out_ready = !(c >= 5 && c <= 7);
      sub = 1'b0;
      if (sent < 8) begin
        in_valid = 1'b1; a = vals[sent]; b = vals[sent]; in_tag = sent[3:0];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (c >= 5 && c <= 7) begin
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready cycle=%0d got=%b want=0", c, in_ready); end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stall_out_valid cycle=%0d got=%b want=1", c, out_valid); end
        if (c == 5) begin
          held_res = result; held_tag = out_tag;
        end else begin
          total++;
          if (result !== held_res || out_tag !== held_tag) begin
            bad++; $display("FAIL stall_hold cycle=%0d got=%h/%h want=%h/%h", c, result, out_tag, held_res, held_tag);
          end
        end
      end
      if (out_valid && out_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL stream_extra got=%h tag=%h want=none", result, out_tag);
        end else begin
          want = exp_q.pop_front(); want_tag = tag_q.pop_front();
          if (result !== want || out_tag !== want_tag) begin
            bad++; $display("FAIL stream_result got=%h tag=%h want=%h tag=%h", result, out_tag, want, want_tag);
          end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(dbl[sent]); tag_q.push_back(sent[3:0]); sent++;
      end
    end
    total++; if (got !== 8) begin bad++; $display("FAIL stream_count got=%0d want=8", got); end
    total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL stream_pending got=%0d want=0", exp_q.size()); end
    in_valid = 1'b0; out_ready = 1'b1;
    stale = 0;
    repeat (6) begin
      @(negedge clk); #1;
      if (out_valid) stale++;
    end
    total++; if (stale !== 0) begin bad++; $display("FAIL stream_duplicate got=%0d want=0", stale); end
  endtask

  task automatic test_reset_mid();
    int stale;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      in_valid = 1'b1; a = 32'h3F800000; b = 32'h3F800000; sub = 1'b0; in_tag = c[3:0];
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL midreset_in_ready got=%b want=0", in_ready); end
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midreset_out_valid got=%b want=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL midreset_ready_after got=%b want=1", in_ready); end
    stale = 0;
    repeat (8) begin
      @(negedge clk); #1;
      if (out_valid) stale++;
    end
    total++; if (stale !== 0) begin bad++; $display("FAIL midreset_stale got=%0d want=0", stale); end
  endtask

  initial begin
    total = 0; bad = 0;
    reset = 1'b1; in_valid = 1'b0; sub = 1'b0; a = '0; b = '0; in_tag = '0; out_ready = 1'b1;
    h_in_valid = 1'b0; h_sub = 1'b0; h_a = '0; h_b = '0; h_in_tag = '0; h_out_ready = 1'b1;
    test_reset();
    test_arith();
    test_subnormal();
    test_half();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
